serial_keymatrix: RTL and testbench
===================================

SERIAL_KEYMATRIX -- requirements
Module: serial_keymatrix

Interface
REQ-001 SHALL have parameter F_CLK, default 25000000, system clock frequency in Hz (informational; used only for derived defaults).
REQ-002 SHALL have parameter HOLD_CYCLES, default 500000, number of cycles a decoded key stays pressed.
REQ-003 SHALL have parameter GAP_CYCLES, default 250000, number of all-released cycles between consecutive keys.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, character FIFO depth; power of two, at least 2.
REQ-005 SHALL have parameter NKEYS, default 64, matrix size; power of two, at least 64.
REQ-006 SHALL have port clk, input, 1, system clock.
REQ-007 SHALL have port resetn, input, 1, reset (synchronous, active-low).
REQ-008 SHALL have port rx_data, input, 8, received character.
REQ-009 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-010 SHALL have port key_rd, input, 1, matrix read strobe.
REQ-011 SHALL have port key_addr, input, log2(NKEYS), matrix row/key index.
REQ-012 SHALL have port key_out, output, 8, registered read data.
REQ-013 SHALL have port fifo_count, output, log2(FIFO_DEPTH)+1, number of queued characters.
REQ-014 SHALL have port overflow, output, 1, sticky flag set when a character is dropped.
REQ-015 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL push rx_data into the FIFO on rx_valid when the FIFO is not full; when full, SHALL drop the character and set overflow.
REQ-017 SHALL, on a simultaneous push and pop at full, perform both operations, leaving fifo_count unchanged and overflow unchanged.
REQ-018 SHALL implement the FSM states IDLE, PRESS, HOLD and GAP.
REQ-019 SHALL move IDLE->PRESS when the FIFO is non-empty, popping the head character in that cycle.
REQ-020 SHALL, in PRESS, clear the whole matrix, set the mapped key bits in one cycle, then move to HOLD.
REQ-021 SHALL remain in HOLD for exactly HOLD_CYCLES cycles, then clear all key bits and move to GAP.
REQ-022 SHALL remain in GAP for exactly GAP_CYCLES cycles, then move to IDLE.
REQ-023 SHALL use the key map: A-Z and a-z map to keys 1-26; 0-9 map to 32-41; CR or LF to 48; BS or DEL to 29; ESC to 49; space to 31; ; : , = . / to 42-47.
REQ-024 SHALL map the following shifted characters to their key plus shift key 53: _ ! " # $ % & \ to 32-39, and ( ) + * < - > ? to 40-47.
REQ-025 SHALL, for an unmapped character, pass through PRESS, HOLD and GAP with no key set, so timing stays uniform.
REQ-026 SHALL, one cycle after key_rd, set key_out to 8'hFE if key key_addr is pressed and to 8'hFF otherwise; without key_rd, key_out SHALL hold its value.
REQ-027 SHALL derive busy and fifo_count combinationally from registered state.

Reset
REQ-028 SHALL, while resetn is low at a clk edge, set FSM=IDLE, FIFO empty (fifo_count=0), all keys released, key_out=8'hFF, overflow=0, and hold/gap counter=0.
REQ-029 SHALL, on reset during HOLD or GAP, discard the in-flight character and all queued characters.

Configuration
REQ-030 SHALL, with SERIAL_KEYMATRIX_FIFO_EN defined, implement the FIFO_DEPTH-entry FIFO as specified.
REQ-031 SHALL, without SERIAL_KEYMATRIX_FIFO_EN, replace the FIFO with a single holding register: accept only when empty, treat fifo_count as 0 or 1, drop and set overflow when occupied, and ignore FIFO_DEPTH.

Verification (HOLD_CYCLES=8, GAP_CYCLES=4, FIFO_DEPTH=4)
REQ-032 SHALL pass: reset, then "A" -> key 1 pressed (key_rd at addr 1 gives 8'hFE) for 8 cycles; addr 2 gives 8'hFF; busy low 14 cycles after the push.
REQ-033 SHALL pass: "!" -> keys 33 and 53 both read 8'hFE during HOLD; both read 8'hFF in GAP.
REQ-034 SHALL pass: six back-to-back rx_valid strobes -> first character is popped and the next 4 are queued, so fifo_count=4, and the sixth is dropped with overflow=1; the five accepted characters are replayed in order.
REQ-035 SHALL pass: 0x7F then 0x01 -> key 29 pressed, then a full cycle with no key pressed; fifo_count returns to 0.
REQ-036 SHALL pass: resetn low for one cycle mid-HOLD -> next cycle busy=0, fifo_count=0, key_out=8'hFF, overflow=0.
REQ-037 SHALL pass: without the macro, two strobes while busy -> second dropped, overflow=1.

Source files
------------

// File: rtl/serial_keymatrix.sv
// Serial-character to key-matrix injector: queued characters are "typed" as timed key presses.
// Define SERIAL_KEYMATRIX_FIFO_EN for the FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module serial_keymatrix #(
  parameter int F_CLK       = 25000000,
  parameter int HOLD_CYCLES = 500000,
  parameter int GAP_CYCLES  = 250000,
  parameter int FIFO_DEPTH  = 16,
  parameter int NKEYS       = 64
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          key_rd,
  input  logic [$clog2(NKEYS)-1:0]      key_addr,
  output logic [7:0]                    key_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);
  localparam int KW   = $clog2(NKEYS);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, PRESS, HOLD, GAP} state_t;

  // Returns {mapped, shifted, key[5:0]}.
  function automatic logic [7:0] map_key(input logic [7:0] c);
    logic [5:0] k;
    logic       v, s;
    k = '0; v = 1'b1; s = 1'b0;
    if (c >= 8'h41 && c <= 8'h5A)      k = 6'(c - 8'h40);
    else if (c >= 8'h61 && c <= 8'h7A) k = 6'(c - 8'h60);
    else if (c >= 8'h30 && c <= 8'h39) k = 6'(c - 8'h10);
    else begin
      case (c)
        8'h0D, 8'h0A: k = 6'd48;
        8'h08, 8'h7F: k = 6'd29;
        8'h1B:        k = 6'd49;
        8'h20:        k = 6'd31;
        ";": k = 6'd42;  ":": k = 6'd43;  ",": k = 6'd44;
        "=": k = 6'd45;  ".": k = 6'd46;  "/": k = 6'd47;
        "_": begin k = 6'd32; s = 1'b1; end
        "!": begin k = 6'd33; s = 1'b1; end
        8'h22: begin k = 6'd34; s = 1'b1; end
        "#": begin k = 6'd35; s = 1'b1; end
        "$": begin k = 6'd36; s = 1'b1; end
        "%": begin k = 6'd37; s = 1'b1; end
        "&": begin k = 6'd38; s = 1'b1; end
        8'h5C: begin k = 6'd39; s = 1'b1; end
        "(": begin k = 6'd40; s = 1'b1; end
        ")": begin k = 6'd41; s = 1'b1; end
        "+": begin k = 6'd42; s = 1'b1; end
        "*": begin k = 6'd43; s = 1'b1; end
        "<": begin k = 6'd44; s = 1'b1; end
        "-": begin k = 6'd45; s = 1'b1; end
        ">": begin k = 6'd46; s = 1'b1; end
        "?": begin k = 6'd47; s = 1'b1; end
        default: v = 1'b0;
      endcase
    end
    return {v, s, k};
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NKEYS-1:0] keys_q, keys_d;
  logic [7:0]       key_out_q, key_out_d;
  logic [7:0]       char_q, char_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       head;
  logic [7:0]       kmap;
  logic             empty, pop, push;

`ifdef SERIAL_KEYMATRIX_FIFO_EN
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    full     = (count_q == (AW+1)'(FIFO_DEPTH));
    empty    = (count_q == '0);
    pop      = (state_q == IDLE) && !empty;
    // A pop in the same cycle frees the slot, so a push at full still fits.
    push     = rx_valid && (!full || pop);
    head     = mem_q[rd_ptr_q];
    if (push) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign fifo_count = count_q;
`else
  logic       occ_q, occ_d;
  logic [7:0] hold_q, hold_d;

  always_comb begin
    occ_d  = occ_q;
    hold_d = hold_q;
    empty  = !occ_q;
    pop    = (state_q == IDLE) && occ_q;
    push   = rx_valid && !occ_q;
    head   = hold_q;
    if (pop) occ_d = 1'b0;
    if (push) begin
      occ_d  = 1'b1;
      hold_d = rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      occ_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      occ_q  <= occ_d;
      hold_q <= hold_d;
    end
  end

  assign fifo_count = {{AW{1'b0}}, occ_q};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    keys_d    = keys_q;
    char_d    = char_q;
    ovf_d     = ovf_q;
    key_out_d = key_out_q;
    kmap      = map_key(char_q);
    if (rx_valid && !push) ovf_d = 1'b1;
    case (state_q)
      IDLE: if (!empty) begin
        state_d = PRESS;
        char_d  = head;
      end
      PRESS: begin
        // Unmapped characters still walk through HOLD/GAP with nothing pressed.
        keys_d = '0;
        if (kmap[7]) keys_d[KW'(kmap[5:0])] = 1'b1;
        if (kmap[7] && kmap[6]) keys_d[53] = 1'b1;
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
        cnt_d   = '0;
        keys_d  = '0;
        state_d = GAP;
      end else cnt_d = cnt_q + 1'b1;
      GAP: if (cnt_q == CW'(GAP_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    if (key_rd) key_out_d = keys_q[key_addr] ? 8'hFE : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      keys_q    <= '0;
      char_q    <= '0;
      ovf_q     <= 1'b0;
      key_out_q <= 8'hFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      keys_q    <= keys_d;
      char_q    <= char_d;
      ovf_q     <= ovf_d;
      key_out_q <= key_out_d;
    end
  end

  assign key_out  = key_out_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_serial_keymatrix.sv
// Directed bench for serial_keymatrix: key-map table plus timing, queueing and reset sequences.
module tb_serial_keymatrix;
  localparam int HOLD = 8, GAP = 4, FD = 4, NK = 64;

  logic       clk = 1'b0, resetn = 1'b0, rx_valid = 1'b0, key_rd = 1'b0;
  logic [7:0] rx_data = '0;
  logic [5:0] key_addr = '0;
  logic [7:0] key_out;
  logic [2:0] fifo_count;
  logic       overflow, busy;
  int         errs = 0, checks = 0, n = 0;

  serial_keymatrix #(.F_CLK(25000000), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
                     .FIFO_DEPTH(FD), .NKEYS(NK)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_rd(key_rd), .key_addr(key_addr), .key_out(key_out),
    .fifo_count(fifo_count), .overflow(overflow), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    int         key;
    bit         mapped;
    bit         shift;
  } vec_t;
  vec_t tv[13];

  task automatic tick;
    @(posedge clk); #1; n++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, n);
    end
  endtask

  task automatic push_tick(input logic [7:0] c);
    rx_valid = 1'b1; rx_data = c;
    tick;
    rx_valid = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input int a, input logic [7:0] exp);
    key_rd = 1'b1; key_addr = 6'(a);
    tick;
    key_rd = 1'b0;
    chk(nm, key_out, exp);
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin tick; k++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{8'h41, 1,  1, 0};   // A
    tv[1]  = '{8'h7A, 26, 1, 0};   // z
    tv[2]  = '{8'h30, 32, 1, 0};   // 0
    tv[3]  = '{8'h39, 41, 1, 0};   // 9
    tv[4]  = '{8'h0D, 48, 1, 0};   // CR
    tv[5]  = '{8'h1B, 49, 1, 0};   // ESC
    tv[6]  = '{8'h20, 31, 1, 0};   // space
    tv[7]  = '{8'h2F, 47, 1, 0};   // /
    tv[8]  = '{8'h21, 33, 1, 1};   // !
    tv[9]  = '{8'h3F, 47, 1, 1};   // ?
    tv[10] = '{8'h5F, 32, 1, 1};   // _
    tv[11] = '{8'h2D, 45, 1, 1};   // -
    tv[12] = '{8'h01, 1,  0, 0};   // unmapped

    tick; tick;
    resetn = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_key_out", key_out, 8'hFF);
    chk("rst_overflow", overflow, 1'b0);

    // 'A': key 1 visible for exactly HOLD reads, idle 14 cycles after the push
    begin
      int cnt = 0;
      n = -1;
      push_tick(8'h41);
      tick;
      rd_chk("A_before", 1, 8'hFF);
      for (int i = 0; i < HOLD; i++) begin
        key_rd = 1'b1; key_addr = 6'd1;
        tick;
        key_rd = 1'b0;
        if (key_out == 8'hFE) cnt++;
      end
      chk("A_hold_len", cnt, HOLD);
      rd_chk("A_after", 1, 8'hFF);
      rd_chk("A_addr2", 2, 8'hFF);
      wait_idle(40);
      chk("A_idle_at", n, 14);
    end

    for (int v = 0; v < 13; v++) begin
      n = -1;
      push_tick(tv[v].ch);
      tick; tick;
      rd_chk($sformatf("map%0d_key", v), tv[v].key, tv[v].mapped ? 8'hFE : 8'hFF);
      rd_chk($sformatf("map%0d_shift", v), 53, tv[v].shift ? 8'hFE : 8'hFF);
      rd_chk($sformatf("map%0d_nbr", v), tv[v].key + 1, 8'hFF);
      while (n < 11) tick;
      rd_chk($sformatf("map%0d_gap_key", v), tv[v].key, 8'hFF);
      rd_chk($sformatf("map%0d_gap_shift", v), 53, 8'hFF);
      wait_idle(40);
      chk($sformatf("map%0d_idle_at", v), n, 14);
    end

    // DEL then unmapped 0x01 queued behind it
    n = -1;
    push_tick(8'h7F);
    tick;
    push_tick(8'h01);
    chk("del_queued", fifo_count, 3'd1);
    rd_chk("del_key29", 29, 8'hFE);
    wait_idle(40);
    chk("del_idle_at", n, 14);
    chk("del_count_idle", fifo_count, 3'd1);
    tick;
    chk("u_busy", busy, 1'b1);
    chk("u_count", fifo_count, 3'd0);
    tick;
    rd_chk("u_key29", 29, 8'hFF);
    rd_chk("u_key1", 1, 8'hFF);
    wait_idle(40);
    chk("u_idle_at", n, 28);
    chk("u_count_end", fifo_count, 3'd0);

    // reset mid-HOLD discards in-flight and queued characters
    n = -1;
    push_tick(8'h42);
    tick;
    push_tick(8'h43);
    push_tick(8'h44);
`ifdef SERIAL_KEYMATRIX_FIFO_EN
    chk("mr_count", fifo_count, 3'd2);
`else
    chk("mr_overflow", overflow, 1'b1);
`endif
    rd_chk("mr_keyB", 2, 8'hFE);
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_count0", fifo_count, 3'd0);
    chk("mr_key_out", key_out, 8'hFF);
    chk("mr_overflow0", overflow, 1'b0);
    tick; tick;
    chk("mr_stays_idle", busy, 1'b0);

`ifdef SERIAL_KEYMATRIX_FIFO_EN
    // six back-to-back strobes: 1 popped, 4 queued, 1 dropped
    n = -1;
    for (int i = 0; i < 6; i++) push_tick(8'h41 + 8'(i));
    chk("six_count", fifo_count, 3'd4);
    chk("six_overflow", overflow, 1'b1);
    for (int k = 0; k < 5; k++) begin
      while (n < 5 + 14 * k) tick;
      rd_chk($sformatf("six_replay%0d", k), k + 1, 8'hFE);
    end
    while (n < 76) tick;
    chk("six_done_busy", busy, 1'b0);
    chk("six_done_count", fifo_count, 3'd0);
`else
    // holding register: second strobe while occupied is dropped
    n = -1;
    push_tick(8'h41);
    tick; tick; tick;
    push_tick(8'h42);
    push_tick(8'h43);
    chk("hr_overflow", overflow, 1'b1);
    chk("hr_count", fifo_count, 3'd1);
    while (n < 19) tick;
    rd_chk("hr_keyB", 2, 8'hFE);
    rd_chk("hr_keyC", 3, 8'hFF);
    wait_idle(40);
    chk("hr_idle_at", n, 28);
    tick; tick;
    chk("hr_no_C", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
